// File: rtl/board_ctrl_pkg.sv
// Shared types and helpers for the board reset sequencer.
//  rst_seq_state_e : sequencer FSM states
//  min_idx()       : lowest set bit index of a request vector (MAX_VEC if none)
package board_ctrl_pkg;

   typedef enum logic [1:0] {
      ASSERT,
      RELEASE,
      RUN
   } rst_seq_state_e;

   // Widest request vector min_idx() accepts; requests are zero-extended to this.
   localparam int MAX_VEC = 32;

   function automatic int min_idx(input logic [MAX_VEC-1:0] vec);
      int r;
      r = MAX_VEC;
      for (int i = MAX_VEC - 1; i >= 0; i--) begin
         if (vec[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchroniser followed by a stability
// counter. The debounced level only flips after the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
//  clk_i   in  clock
//  rst_i   in  synchronous active-high reset
//  btn_i   in  raw asynchronous button
//  btn_o   out debounced level
//  rise_o  out 1-cycle pulse when btn_o goes 0->1
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic btn_o,
   output logic rise_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          r_s1;
   logic          r_s2;
   logic          r_lvl;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_lvl  <= 1'b0;
         r_rise <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_s1   <= btn_i;
         r_s2   <= r_s1;
         r_rise <= 1'b0;
         if (r_s2 == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            // Disagreement has persisted long enough: adopt the new level.
            r_lvl  <= r_s2;
            r_rise <= r_s2;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign btn_o  = r_lvl;
   assign rise_o = r_rise;

endmodule

// File: rtl/board_reset_seq.sv
// Board-level reset sequencer and button conditioner.
// Debounces NUM_BTN buttons, drives NUM_RST active-low domain resets released
// in index order, re-sequences a domain and all higher domains on request,
// and exposes a free-running heartbeat bit for an LED.
//  clk_i         in  clock
//  rst_i         in  synchronous active-high reset (from synchronised PLL lock)
//  btn_i         in  raw buttons, active-high
//  sw_rst_req_i  in  1-cycle software reset request per domain
//  btn_o         out debounced button levels
//  btn_rise_o    out 1-cycle pulse per debounced 0->1 transition
//  rst_no        out registered active-low domain resets
//  busy_o        out high while any domain is held or the sequence runs
//  heartbeat_o   out heartbeat counter bit HB_BIT
module board_reset_seq
   import board_ctrl_pkg::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int NUM_RST         = 2,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int RST_STRETCH     = 16,
   parameter int RST_GAP         = 8,
   parameter int BTN_RST_IDX     = 1,
   parameter int HB_BIT          = 20
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_BTN-1:0] btn_i,
   input  logic [NUM_RST-1:0] sw_rst_req_i,
   output logic [NUM_BTN-1:0] btn_o,
   output logic [NUM_BTN-1:0] btn_rise_o,
   output logic [NUM_RST-1:0] rst_no,
   output logic               busy_o,
   output logic               heartbeat_o
);

   localparam int IW   = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
   localparam int CMAX = (RST_STRETCH > RST_GAP) ? RST_STRETCH : RST_GAP;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_RST - 1);

   rst_seq_state_e     r_state;
   logic [IW-1:0]      r_first;
   logic [IW-1:0]      r_idx;
   logic [CW-1:0]      r_cnt;
   logic [NUM_RST-1:0] r_rst_n;
   logic               r_busy;
   logic [HB_BIT:0]    r_hb;

   logic [NUM_BTN-1:0] w_btn;
   logic [NUM_BTN-1:0] w_rise;
   logic [MAX_VEC-1:0] w_req;
   logic               w_req_any;
   logic [IW-1:0]      w_d;
   logic [IW-1:0]      w_lo;
   logic [IW-1:0]      w_first_new;
   logic [NUM_RST-1:0] w_keep;

   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .btn_i (btn_i[b]),
         .btn_o (w_btn[b]),
         .rise_o(w_rise[b])
      );
   end

   // Restart point on a request. w_lo is the lowest domain still held: in
   // ASSERT that is first_q, in RELEASE it is the next domain to release
   // (lower ones are already out and must not be disturbed). In RUN nothing
   // is held, so the request index alone decides.
   always_comb begin
      w_req                = '0;
      w_req[NUM_RST-1:0]   = sw_rst_req_i;
      w_req[0]             = w_req[0] | w_rise[BTN_RST_IDX];
      w_req_any            = |w_req;
      w_d                  = IW'(min_idx(w_req));
      w_lo                 = (r_state == RELEASE) ? r_idx : r_first;
      w_first_new          = ((r_state == RUN) || (w_d < w_lo)) ? w_d : w_lo;
      w_keep               = '0;
      for (int k = 0; k < NUM_RST; k++) begin
         w_keep[k] = (k < int'(w_first_new));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ASSERT;
         r_first <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_rst_n <= '0;
         r_busy  <= 1'b1;
         r_hb    <= '0;
      end else begin
         r_hb <= r_hb + 1'b1;
         if (w_req_any) begin
            // A request always wins over a release due on the same cycle.
            r_first <= w_first_new;
            r_rst_n <= r_rst_n & w_keep;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ASSERT;
         end else begin
            case (r_state)
               ASSERT: begin
                  if (r_cnt == CW'(RST_STRETCH - 1)) begin
                     r_rst_n[r_first] <= 1'b1;
                     r_idx            <= r_first + IW'(1);
                     r_cnt            <= '0;
                     if (r_first == LAST) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= RELEASE;
                     end
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               RELEASE: begin
                  if (r_cnt == CW'(RST_GAP - 1)) begin
                     r_rst_n[r_idx] <= 1'b1;
                     r_cnt          <= '0;
                     if (r_idx == LAST) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                     end else begin
                        r_idx <= r_idx + IW'(1);
                     end
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               default: begin
                  r_rst_n <= '1;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign btn_o       = w_btn;
   assign btn_rise_o  = w_rise;
   assign rst_no      = r_rst_n;
   assign busy_o      = r_busy;
   assign heartbeat_o = r_hb[HB_BIT];

endmodule

// File: tb/tb_board_reset_seq.sv
// Bench for board_reset_seq. The reference model works on release times:
// each domain k carries the clock edge at which it comes out of reset, and a
// request simply reschedules every domain from the restart point upward.
module tb_board_reset_seq;

   localparam int NB = 4;
   localparam int NR = 3;
   localparam int DC = 8;
   localparam int ST = 4;
   localparam int GP = 3;
   localparam int BI = 1;
   localparam int HB = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn;
   logic [NR-1:0] sw;
   logic [NB-1:0] btn_o;
   logic [NB-1:0] btn_rise_o;
   logic [NR-1:0] rst_no;
   logic          busy_o;
   logic          heartbeat_o;

   int checks = 0;
   int errors = 0;

   // model state
   int            n = 0;
   int            rel[NR];
   int            hb_cnt = 0;
   logic [NB-1:0] m_h1 = '0, m_h2 = '0, m_lvl = '0, m_rise = '0;
   int            m_run[NB];

   board_reset_seq #(
      .NUM_BTN(NB), .NUM_RST(NR), .DEBOUNCE_CYCLES(DC),
      .RST_STRETCH(ST), .RST_GAP(GP), .BTN_RST_IDX(BI), .HB_BIT(HB)
   ) dut (
      .clk_i(clk), .rst_i(rst), .btn_i(btn), .sw_rst_req_i(sw),
      .btn_o(btn_o), .btn_rise_o(btn_rise_o), .rst_no(rst_no),
      .busy_o(busy_o), .heartbeat_o(heartbeat_o)
   );

   always #5 clk = ~clk;

   function automatic logic [NR-1:0] exp_rst();
      logic [NR-1:0] e;
      for (int k = 0; k < NR; k++) e[k] = (n >= rel[k]);
      return e;
   endfunction

   function automatic logic exp_busy();
      logic b;
      b = 1'b0;
      for (int k = 0; k < NR; k++) if (rel[k] > n) b = 1'b1;
      return b;
   endfunction

   function automatic logic exp_hb();
      return logic'((hb_cnt >> HB) & 1);
   endfunction

   // Advance one clock edge and the model with it; returns 1 time unit later.
   task automatic step();
      logic [NR-1:0] req;
      int d, lo, f;
      @(posedge clk);
      n++;
      if (rst) begin
         for (int k = 0; k < NR; k++) rel[k] = n + ST + k * GP;
         hb_cnt = 0;
         m_h1 = '0; m_h2 = '0; m_lvl = '0; m_rise = '0;
         for (int b = 0; b < NB; b++) m_run[b] = 0;
      end else begin
         hb_cnt++;
         req = sw;
         req[0] = req[0] | m_rise[BI];
         if (req != '0) begin
            d = NR;
            for (int k = NR - 1; k >= 0; k--) if (req[k]) d = k;
            lo = NR;
            for (int k = NR - 1; k >= 0; k--) if (rel[k] >= n) lo = k;
            f = (d < lo) ? d : lo;
            for (int k = f; k < NR; k++) rel[k] = n + ST + (k - f) * GP;
         end
         for (int b = 0; b < NB; b++) begin
            // consecutive edges the synchronised level disagreed with btn_o
            m_run[b] = (m_h2[b] != m_lvl[b]) ? m_run[b] + 1 : 0;
            m_rise[b] = 1'b0;
            if (m_run[b] == DC) begin
               m_lvl[b]  = m_h2[b];
               m_rise[b] = m_h2[b];
               m_run[b]  = 0;
            end
            m_h2[b] = m_h1[b];
            m_h1[b] = btn[b];
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; sw = '0; btn = '1;
      repeat (3) step();
      checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL reset rst_no got=%b exp=000", rst_no); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL reset busy got=%b exp=1", busy_o); end
      checks++; if (btn_o !== 4'b0000) begin errors++; $display("FAIL reset btn_o got=%b exp=0000", btn_o); end
      checks++; if (btn_rise_o !== 4'b0000) begin errors++; $display("FAIL reset rise got=%b exp=0000", btn_rise_o); end
      checks++; if (heartbeat_o !== 1'b0) begin errors++; $display("FAIL reset hb got=%b exp=0", heartbeat_o); end
      btn = '0;
   endtask

   task automatic test_power_on();
      logic [NR-1:0] e;
      rst = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         step();
         e = (c < 4) ? 3'b000 : (c < 7) ? 3'b001 : (c < 10) ? 3'b011 : 3'b111;
         checks++; if (rst_no !== e) begin errors++; $display("FAIL power_on rst_no c=%0d got=%b exp=%b", c, rst_no, e); end
         checks++; if (busy_o !== (c < 10)) begin errors++; $display("FAIL power_on busy c=%0d got=%b exp=%b", c, busy_o, c < 10); end
         checks++; if (heartbeat_o !== exp_hb()) begin errors++; $display("FAIL power_on hb c=%0d got=%b exp=%b", c, heartbeat_o, exp_hb()); end
      end
   endtask

   task automatic test_sw_req();
      logic [NR-1:0] e;
      sw = 3'b010; step(); sw = '0;
      checks++; if (rst_no !== 3'b001) begin errors++; $display("FAIL sw_req first got=%b exp=001", rst_no); end
      for (int c = 1; c <= 9; c++) begin
         step();
         e = (c < 4) ? 3'b001 : (c < 7) ? 3'b011 : 3'b111;
         checks++; if (rst_no !== e) begin errors++; $display("FAIL sw_req rst_no c=%0d got=%b exp=%b", c, rst_no, e); end
         checks++; if (busy_o !== exp_busy()) begin errors++; $display("FAIL sw_req busy c=%0d got=%b exp=%b", c, busy_o, exp_busy()); end
      end
   endtask

   task automatic test_btn_debounce();
      int rises = 0;
      btn[1] = 1'b1; repeat (5) step();
      btn[1] = 1'b0;
      for (int c = 0; c < 15; c++) begin
         step();
         checks++; if (btn_o[1] !== 1'b0 || btn_rise_o[1] !== 1'b0) begin errors++; $display("FAIL glitch c=%0d btn=%b rise=%b exp=0/0", c, btn_o[1], btn_rise_o[1]); end
      end
      btn[1] = 1'b1;
      for (int c = 0; c < 37; c++) begin
         if (c == 12) btn[1] = 1'b0;
         step();
         if (btn_rise_o[1] === 1'b1) rises++;
         checks++; if (btn_o !== m_lvl || btn_rise_o !== m_rise) begin errors++; $display("FAIL hold btn c=%0d got=%b/%b exp=%b/%b", c, btn_o, btn_rise_o, m_lvl, m_rise); end
         checks++; if (rst_no !== exp_rst()) begin errors++; $display("FAIL hold rst_no c=%0d got=%b exp=%b", c, rst_no, exp_rst()); end
      end
      checks++; if (rises != 1) begin errors++; $display("FAIL hold rise_count got=%0d exp=1", rises); end
      checks++; if (rst_no !== 3'b111) begin errors++; $display("FAIL hold final got=%b exp=111", rst_no); end
   endtask

   task automatic test_simultaneous();
      logic [NR-1:0] e;
      bit found = 0;
      btn[1] = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (m_rise[1]) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL simul timeout rise got=0 exp=1"); end
      sw = 3'b110; step(); sw = '0;
      checks++; if (rst_no !== 3'b000) begin errors++; $display("FAIL simul first got=%b exp=000", rst_no); end
      for (int c = 1; c <= 11; c++) begin
         step();
         e = (c < 4) ? 3'b000 : (c < 7) ? 3'b001 : (c < 10) ? 3'b011 : 3'b111;
         checks++; if (rst_no !== e) begin errors++; $display("FAIL simul rst_no c=%0d got=%b exp=%b", c, rst_no, e); end
      end
      btn[1] = 1'b0;
      for (int c = 0; c < 14; c++) begin
         step();
         checks++; if (btn_o !== m_lvl || rst_no !== exp_rst()) begin errors++; $display("FAIL simul tail c=%0d btn=%b rst=%b exp=%b/%b", c, btn_o, rst_no, m_lvl, exp_rst()); end
      end
   endtask

   task automatic test_release_req();
      logic [NR-1:0] e;
      sw = 3'b001; step(); sw = '0;
      repeat (5) step();
      checks++; if (rst_no !== 3'b001) begin errors++; $display("FAIL rel_req pre got=%b exp=001", rst_no); end
      sw = 3'b100; step(); sw = '0;
      checks++; if (rst_no !== 3'b001) begin errors++; $display("FAIL rel_req first got=%b exp=001", rst_no); end
      for (int c = 1; c <= 8; c++) begin
         step();
         e = (c < 4) ? 3'b001 : (c < 7) ? 3'b011 : 3'b111;
         checks++; if (rst_no !== e) begin errors++; $display("FAIL rel_req rst_no c=%0d got=%b exp=%b", c, rst_no, e); end
      end
   endtask

   task automatic test_mid_reset();
      sw = 3'b001; step(); sw = '0;
      repeat (6) step();
      rst = 1'b1; step(); rst = 1'b0;
      checks++; if (rst_no !== 3'b000 || busy_o !== 1'b1) begin errors++; $display("FAIL mid_rst outs got=%b/%b exp=000/1", rst_no, busy_o); end
      checks++; if (btn_o !== 4'b0000 || heartbeat_o !== 1'b0) begin errors++; $display("FAIL mid_rst btn/hb got=%b/%b exp=0000/0", btn_o, heartbeat_o); end
      for (int c = 1; c <= 20; c++) begin
         step();
         checks++; if (heartbeat_o !== logic'((c >> 3) & 1)) begin errors++; $display("FAIL mid_rst hb c=%0d got=%b exp=%0d", c, heartbeat_o, (c >> 3) & 1); end
         checks++; if (rst_no !== exp_rst()) begin errors++; $display("FAIL mid_rst rst_no c=%0d got=%b exp=%b", c, rst_no, exp_rst()); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         sw  = ($urandom_range(0, 29) == 0) ? NR'($urandom_range(1, 7)) : '0;
         rst = ($urandom_range(0, 249) == 0);
         for (int b = 0; b < NB; b++) if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
         step();
         checks++; if (rst_no !== exp_rst() || busy_o !== exp_busy()) begin errors++; $display("FAIL random seq c=%0d got=%b/%b exp=%b/%b", c, rst_no, busy_o, exp_rst(), exp_busy()); end
         checks++; if (btn_o !== m_lvl || btn_rise_o !== m_rise) begin errors++; $display("FAIL random btn c=%0d got=%b/%b exp=%b/%b", c, btn_o, btn_rise_o, m_lvl, m_rise); end
         checks++; if (heartbeat_o !== exp_hb()) begin errors++; $display("FAIL random hb c=%0d got=%b exp=%b", c, heartbeat_o, exp_hb()); end
      end
   endtask

   initial begin
      for (int b = 0; b < NB; b++) m_run[b] = 0;
      for (int k = 0; k < NR; k++) rel[k] = 0;
      rst = 1'b1; sw = '0; btn = '0;
      test_reset();
      test_power_on();
      test_sw_req();
      test_btn_debounce();
      test_simultaneous();
      test_release_req();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
